// File: rtl/ebpf_pc_unit.sv
// ebpf_pc_unit: program counter and fetch sequencer for the eBPF soft core.
// Fetches one instruction at a time and derives the next PC from retire feedback.
module ebpf_pc_unit #(
  parameter int unsigned       ADDR_W   = 12,
  parameter int unsigned       INSN_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  input  logic [INSN_W-1:0] insn_in,
  input  logic              insn_valid,
  output logic [INSN_W-1:0] insn_out,
  output logic              insn_out_valid,
  input  logic              stall,
  input  logic              adv_valid,
  input  logic              adv_wide,
  input  logic              br_taken,
  input  logic [15:0]       br_off,
  input  logic              exit_req,
  output logic              running,
  output logic              done,
  output logic              fault
);

  // Wide enough that neither the PC nor a full 16-bit offset can wrap silently.
  localparam int unsigned CW = ((ADDR_W > 16) ? ADDR_W : 16) + 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSN_W-1:0]   r_insn;
  logic                r_insn_valid;
  logic                r_fetch_valid;
  logic                r_running;
  logic                r_done;
  logic                r_fault;

  logic [CW-1:0]       w_pc_ext;
  logic [CW-1:0]       w_step;
  logic [CW-1:0]       w_off_ext;
  logic [CW-1:0]       w_next;
  logic                w_next_oob;

  // Next-PC arithmetic in signed CW bits; any set bit above ADDR_W means negative or past the end.
  always_comb begin
    w_pc_ext   = {{(CW-ADDR_W){1'b0}}, r_pc};
    w_step     = {{(CW-2){1'b0}}, 2'b01} + {{(CW-1){1'b0}}, adv_wide};
    w_off_ext  = br_taken ? {{(CW-16){br_off[15]}}, br_off} : {CW{1'b0}};
    w_next     = w_pc_ext + w_step + w_off_ext;
    w_next_oob = (w_next[CW-1:ADDR_W] != {(CW-ADDR_W){1'b0}});
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_insn        <= {INSN_W{1'b0}};
      r_insn_valid  <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_running     <= 1'b0;
      r_done        <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc          <= start_pc;
            r_fetch_valid <= 1'b1;
            r_running     <= 1'b1;
            r_state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (fetch_ready) begin
            r_fetch_valid <= 1'b0;
            r_state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (insn_valid) begin
            r_insn       <= insn_in;
            r_insn_valid <= 1'b1;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (adv_valid && !stall) begin
            if (exit_req) begin
              r_done    <= 1'b1;
              r_running <= 1'b0;
              r_state   <= S_DONE;
            end else if (w_next_oob) begin
              r_fault      <= 1'b1;
              r_running    <= 1'b0;
              r_insn_valid <= 1'b0;
              r_state      <= S_FAULT;
            end else begin
              r_pc          <= w_next[ADDR_W-1:0];
              r_insn_valid  <= 1'b0;
              r_fetch_valid <= 1'b1;
              r_state       <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_done       <= 1'b0;
          r_insn_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
        S_FAULT: begin
          if (start) begin
            r_fault       <= 1'b0;
            r_pc          <= start_pc;
            r_fetch_valid <= 1'b1;
            r_running     <= 1'b1;
            r_state       <= S_FETCH;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_fetch_valid <= 1'b0;
          r_insn_valid  <= 1'b0;
          r_running     <= 1'b0;
          r_done        <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_addr     = r_pc;
  assign fetch_valid    = r_fetch_valid;
  assign insn_out       = r_insn;
  assign insn_out_valid = r_insn_valid;
  assign running        = r_running;
  assign done           = r_done;
  assign fault          = r_fault;

endmodule

// File: tb/tb_ebpf_pc_unit.sv
// Self-checking bench for ebpf_pc_unit: a scoreboard of expected fetch addresses is filled
// as starts/retires are driven and drained as the DUT issues fetches.
module tb_ebpf_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] start_pc;
  logic [11:0] fetch_addr;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [63:0] insn_in;
  logic        insn_valid;
  logic [63:0] insn_out;
  logic        insn_out_valid;
  logic        stall;
  logic        adv_valid;
  logic        adv_wide;
  logic        br_taken;
  logic [15:0] br_off;
  logic        exit_req;
  logic        running;
  logic        done;
  logic        fault;

  int          n_vec = 0;
  int          n_err = 0;
  int          cur_pc = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  ebpf_pc_unit #(.ADDR_W(12), .INSN_W(64), .RESET_PC(12'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .fetch_addr(fetch_addr), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .insn_in(insn_in), .insn_valid(insn_valid), .insn_out(insn_out),
    .insn_out_valid(insn_out_valid), .stall(stall), .adv_valid(adv_valid),
    .adv_wide(adv_wide), .br_taken(br_taken), .br_off(br_off), .exit_req(exit_req),
    .running(running), .done(done), .fault(fault)
  );

  function automatic logic [63:0] pat(input logic [11:0] a);
    return {32'hC0DE_5EED, 20'h0_0000, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [11:0] pc);
    start = 1'b1; start_pc = pc;
    exp_q.push_back(pc);
    cyc();
    start = 1'b0;
  endtask

  // Acts as instruction memory for one fetch: optional ready backpressure, 1-cycle read latency.
  task automatic serve(input int hold);
    logic [11:0] a;
    logic [11:0] e;
    int t;
    t = 0;
    while (!fetch_valid && t < 20) begin
      cyc();
      t++;
    end
    chk("fetch_valid_seen", fetch_valid, 1'b1);
    if (fetch_valid) begin
      a = fetch_addr;
      chk("sb_depth", exp_q.size(), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("fetch_addr", a, e);
        for (int i = 0; i < hold; i++) begin
          cyc();
          chk("bp_valid", fetch_valid, 1'b1);
          chk("bp_addr", fetch_addr, e);
        end
        fetch_ready = 1'b1;
        cyc();
        fetch_ready = 1'b0;
        chk("wait_valid_low", fetch_valid, 1'b0);
        insn_valid = 1'b1; insn_in = pat(e);
        cyc();
        insn_valid = 1'b0; insn_in = 64'h0;
        chk("insn_out_valid", insn_out_valid, 1'b1);
        chk("insn_out", insn_out, pat(e));
        cur_pc = int'(e);
      end
    end
  endtask

  // Retire the held instruction; the bench model predicts sequential / LDDW / branch / exit / fault.
  task automatic retire(input logic wide, input logic br, input int off, input logic ex);
    int nx;
    logic [15:0] off16;
    nx = cur_pc + 1 + (wide ? 1 : 0) + (br ? off : 0);
    off16 = off[15:0];
    adv_valid = 1'b1; adv_wide = wide; br_taken = br; br_off = off16; exit_req = ex;
    cyc();
    adv_valid = 1'b0; adv_wide = 1'b0; br_taken = 1'b0; br_off = 16'h0; exit_req = 1'b0;
    if (ex) begin
      chk("done_pulse", done, 1'b1);
      chk("done_running", running, 1'b0);
      cyc();
      chk("done_clear", done, 1'b0);
      chk("exit_no_fetch", fetch_valid, 1'b0);
      cyc();
      chk("exit_idle_fetch", fetch_valid, 1'b0);
    end else if (nx < 0 || nx >= 4096) begin
      chk("fault_set", fault, 1'b1);
      chk("fault_no_fetch", fetch_valid, 1'b0);
      chk("fault_iov", insn_out_valid, 1'b0);
      cyc();
      chk("fault_sticky", fault, 1'b1);
    end else begin
      exp_q.push_back(nx[11:0]);
      chk("retire_fetch_next", fetch_valid, 1'b1);
      chk("retire_iov_clr", insn_out_valid, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; start_pc = 12'd0; fetch_ready = 1'b0;
    insn_in = 64'h0; insn_valid = 1'b0; stall = 1'b0; adv_valid = 1'b0;
    adv_wide = 1'b0; br_taken = 1'b0; br_off = 16'h0; exit_req = 1'b0;
    cyc(); cyc();
    chk("rst_fetch_valid", fetch_valid, 1'b0);
    chk("rst_fetch_addr", fetch_addr, 12'd0);
    chk("rst_insn_out", insn_out, 64'h0);
    chk("rst_iov", insn_out_valid, 1'b0);
    chk("rst_running", running, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_fault", fault, 1'b0);
    rst_n = 1'b1;
    cyc();

    // Sequential program from 5
    do_start(12'd5);
    chk("start_running", running, 1'b1);
    serve(0);
    for (int k = 0; k < 3; k++) begin
      retire(1'b0, 1'b0, 0, 1'b0);
      serve(0);
    end
    // Start is ignored while running
    start = 1'b1; start_pc = 12'd99;
    cyc();
    start = 1'b0;
    chk("start_ignored_pc", fetch_addr, 12'd8);

    // Stall drops the retire; insn_out held
    stall = 1'b1; adv_valid = 1'b1;
    cyc();
    stall = 1'b0; adv_valid = 1'b0;
    chk("stall_iov", insn_out_valid, 1'b1);
    chk("stall_insn", insn_out, pat(12'd8));
    chk("stall_pc", fetch_addr, 12'd8);
    chk("stall_no_fetch", fetch_valid, 1'b0);
    retire(1'b0, 1'b0, 0, 1'b1);

    // LDDW then backward branch
    do_start(12'd10);
    serve(4);
    retire(1'b1, 1'b0, 0, 1'b0);
    serve(0);
    retire(1'b0, 1'b1, -3, 1'b0);
    serve(2);
    retire(1'b1, 1'b1, 5, 1'b0);
    serve(0);
    retire(1'b0, 1'b0, 0, 1'b1);

    // EXIT wins over a taken branch
    do_start(12'd20);
    serve(0);
    retire(1'b0, 1'b1, 7, 1'b1);
    chk("exit_running", running, 1'b0);

    // Fault past the end, recovery by start, fault below zero
    do_start(12'd4090);
    serve(0);
    retire(1'b0, 1'b1, 10, 1'b0);
    chk("fault_pc_held", fetch_addr, 12'd4090);
    do_start(12'd0);
    chk("fault_cleared", fault, 1'b0);
    serve(0);
    retire(1'b0, 1'b1, -2, 1'b0);
    do_start(12'd4094);
    serve(0);
    retire(1'b0, 1'b0, 0, 1'b0);
    serve(0);
    retire(1'b0, 1'b0, 0, 1'b0);

    // Reset with a fetch outstanding; a late insn_valid is ignored in IDLE
    do_start(12'd33);
    void'(exp_q.pop_front());
    fetch_ready = 1'b1;
    cyc();
    fetch_ready = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    insn_valid = 1'b1; insn_in = pat(12'd33);
    cyc();
    insn_valid = 1'b0; insn_in = 64'h0;
    cyc();
    chk("late_iov", insn_out_valid, 1'b0);
    chk("late_insn", insn_out, 64'h0);
    chk("late_running", running, 1'b0);
    chk("late_fault", fault, 1'b0);
    chk("sb_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
